// File: rtl/uc_arbiter.sv
// Unit-clause-queue writer: per-engine holding registers, round-robin arbitration,
// one literal per cycle into the queue. Optional literal dedup under `UCA_DEDUP_EN.
`ifndef UC_LENGTH
`define UC_LENGTH 64
`endif

module uc_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = $clog2(`UC_LENGTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_ENG-1:0]              eng2uca_valid,
  input  logic [NUM_ENG-1:0][LIT_W-1:0]   eng2uca_lit,
  output logic [NUM_ENG-1:0]              uca2eng_ready,
  input  logic                            ucq_full,
  output logic                            uca_push,
  output logic [LIT_W-1:0]                uca2ucq
`ifdef UCA_DEDUP_EN
  ,
  output logic [15:0]                     dup_cnt
`endif
);

  localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ENG - 1);

  logic [NUM_ENG-1:0] hold_vld;
  logic [LIT_W-1:0]   hold_lit [NUM_ENG];
  logic [PTR_W-1:0]   rr_ptr;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic [LIT_W-1:0]   win_lit;
  logic               drop;
  logic               take;
  logic [NUM_ENG-1:0] capture;

  // Modular add kept explicit so NUM_ENG need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_ENG) s = s - NUM_ENG;
    return PTR_W'(s);
  endfunction

  // NOTE: every always_comb output gets a default first, otherwise a missed
  // branch infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (!win_found && hold_vld[ptr_add(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_add(rr_ptr, k);
      end
    end
  end

  assign win_lit  = hold_lit[win_idx];
  assign win_next = (win_idx == LAST_PTR) ? '0 : win_idx + 1'b1;

`ifdef UCA_DEDUP_EN
  logic [`UC_LENGTH-1:0] seen;

  // A repeated literal is discarded even while the queue is full.
  assign drop = win_found & seen[win_lit] & ~rst & ~flush;
`else
  assign drop = 1'b0;
`endif

  assign uca_push      = win_found & ~ucq_full & ~flush & ~rst & ~drop;
  assign take          = uca_push | drop;
  assign uca2ucq       = uca_push ? win_lit : '0;
  assign uca2eng_ready = ~hold_vld & {NUM_ENG{~rst & ~flush}};
  assign capture       = eng2uca_valid & uca2eng_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      hold_vld <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (capture[i]) hold_vld[i] <= 1'b1;
      end
      // A held source is never ready, so capture and clear cannot collide.
      if (take) begin
        hold_vld[win_idx] <= 1'b0;
        rr_ptr            <= win_next;
      end
    end
  end

  // NOTE: the literal array carries no reset; its contents are ignored
  // whenever the matching hold_vld bit is clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENG; i++) begin
      if (capture[i]) hold_lit[i] <= eng2uca_lit[i];
    end
  end

`ifdef UCA_DEDUP_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      seen    <= '0;
      dup_cnt <= '0;
    end else begin
      if (uca_push) seen[win_lit] <= 1'b1;
      if (drop && dup_cnt != 16'hFFFF) dup_cnt <= dup_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: expected literals are queued at capture
// and compared in push order by a negedge monitor.
`ifndef UC_LENGTH
`define UC_LENGTH 64
`endif

module tb_uc_arbiter;

  localparam int NUM_ENG = 4;
  localparam int LIT_W   = $clog2(`UC_LENGTH);

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [NUM_ENG-1:0]            valid;
  logic [NUM_ENG-1:0][LIT_W-1:0] lit;
  logic [NUM_ENG-1:0]            ready;
  logic                          full;
  logic                          uca_push;
  logic [LIT_W-1:0]              uca2ucq;
`ifdef UCA_DEDUP_EN
  logic [15:0]                   dup_cnt;
`endif

  always #5 clk = ~clk;

  uc_arbiter #(.NUM_ENG(NUM_ENG), .LIT_W(LIT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .eng2uca_valid (valid),
    .eng2uca_lit   (lit),
    .uca2eng_ready (ready),
    .ucq_full      (full),
    .uca_push      (uca_push),
    .uca2ucq       (uca2ucq)
`ifdef UCA_DEDUP_EN
    ,
    .dup_cnt       (dup_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  logic [LIT_W-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every push must match the oldest expected literal.
  always @(negedge clk) begin
    if (uca_push === 1'b1) begin
      push_cnt++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("push_lit", 32'(uca2ucq), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk);
    #1;
    check(tag, 32'(sb.size()), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n0, n1, cyc, pc0;
  logic [NUM_ENG-1:0] hs;

  initial begin
    rst = 1'b1; flush = 1'b0; valid = '0; lit = '0; full = 1'b0;

    // Reset values
    step(); step();
    @(negedge clk);
    check("rst_push",  32'(uca_push), 32'd0);
    check("rst_data",  32'(uca2ucq),  32'd0);
    check("rst_ready", 32'(ready),    32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'hF);
    check("rr_after_rst", 32'(dut.rr_ptr), 32'd0);

    // Single source: literal 5 pushed one cycle after capture
    step();
    valid = 4'b0001; lit[0] = LIT_W'(5); sb.push_back(LIT_W'(5));
    step();
    valid = '0;
    @(negedge clk);
    check("t1_push",   32'(uca_push), 32'd1);
    check("t1_data",   32'(uca2ucq),  32'd5);
    check("t1_ready0", 32'(ready[0]), 32'd0);
    @(negedge clk);
    check("t1_ready0_back", 32'(ready[0]), 32'd1);
    check("t1_push_idle",   32'(uca_push), 32'd0);

    // All four sources at once from rr_ptr=0, pointer wraps back to 0
    step();
    do_flush();
    valid = 4'b1111;
    for (int i = 0; i < NUM_ENG; i++) begin
      lit[i] = LIT_W'(i + 1);
      sb.push_back(LIT_W'(i + 1));
    end
    step();
    valid = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      @(negedge clk);
      check("t2_push_cont", 32'(uca_push), 32'd1);
    end
    @(negedge clk);
    check("t2_push_done", 32'(uca_push), 32'd0);
    check("t2_rr_wrap", 32'(dut.rr_ptr), 32'd0);
    drain("t2_drain", 4);

    // Back-pressure: literal 7 held while the queue is full
    do_flush();
    full = 1'b1; valid = 4'b0100; lit[2] = LIT_W'(7); sb.push_back(LIT_W'(7));
    step();
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_full_nopush", 32'(uca_push), 32'd0);
      check("t3_full_ready",  32'(ready),    32'b1011);
      check("t3_full_rr",     32'(dut.rr_ptr), 32'd0);
    end
    step();
    full = 1'b0;
    @(negedge clk);
    check("t3_release_push", 32'(uca_push), 32'd1);
    check("t3_release_data", 32'(uca2ucq),  32'd7);
    drain("t3_drain", 4);

    // Fairness: eng0 and eng1 offer every cycle, pushes must alternate
    do_flush();
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 < 10 || n1 < 10) && cyc < 80) begin
      valid  = {2'b00, (n1 < 10), (n0 < 10)};
      lit[0] = LIT_W'(10 + n0);
      lit[1] = LIT_W'(30 + n1);
      @(negedge clk);
      hs = valid & ready;
      step();
      if (hs[0]) begin sb.push_back(LIT_W'(10 + n0)); n0++; end
      if (hs[1]) begin sb.push_back(LIT_W'(30 + n1)); n1++; end
      cyc++;
    end
    valid = '0;
    check("t4_in_budget", 32'(cyc < 80), 32'd1);
    check("t4_cycles", 32'(cyc), 32'd20);
    drain("t4_drain", 30);

    // Flush with two literals held: nothing escapes
    full = 1'b1; valid = 4'b1001; lit[0] = LIT_W'(11); lit[3] = LIT_W'(12);
    step();
    valid = '0; full = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("t5_flush_nopush", 32'(uca_push), 32'd0);
    check("t5_flush_ready",  32'(ready),    32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t5_after_nopush", 32'(uca_push),     32'd0);
    check("t5_after_ready",  32'(ready),        32'hF);
    check("t5_after_hold",   32'(dut.hold_vld), 32'd0);
    check("t5_after_rr",     32'(dut.rr_ptr),   32'd0);

    // Same literal twice
    step();
    do_flush();
    pc0 = push_cnt;
    valid = 4'b0010; lit[1] = LIT_W'(9); sb.push_back(LIT_W'(9));
    step();
    valid = '0;
    step(); step();
    valid = 4'b0010; lit[1] = LIT_W'(9);
`ifndef UCA_DEDUP_EN
    sb.push_back(LIT_W'(9));
`endif
    step();
    valid = '0;
    step(); step();
    drain("t6_drain", 4);
`ifdef UCA_DEDUP_EN
    check("t6_push_count", 32'(push_cnt - pc0), 32'd1);
    check("t6_dup_cnt",    32'(dup_cnt),        32'd1);
`else
    check("t6_push_count", 32'(push_cnt - pc0), 32'd2);
`endif

    // Reset mid-operation discards held literals
    full = 1'b1; valid = 4'b0110; lit[1] = LIT_W'(20); lit[2] = LIT_W'(21);
    step();
    valid = '0; full = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t7_rst_nopush", 32'(uca_push), 32'd0);
    check("t7_rst_ready",  32'(ready),    32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t7_after_nopush", 32'(uca_push),     32'd0);
    check("t7_after_ready",  32'(ready),        32'hF);
    check("t7_after_hold",   32'(dut.hold_vld), 32'd0);

    step();
    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
